por_reset_sequencer: RTL and testbench

//  Receive end of the power-on-reset path: consumes asynchronous porb from the POR cell plus external resetb pin.

---
 rtl/por_seq_pkg.sv | 43 ++++
 rtl/reset_sync_chain.sv | 24 ++
 rtl/por_reset_sequencer.sv | 138 +++++++++++++
 tb/tb_por_reset_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/por_seq_pkg.sv
// Shared types and constants for the power-on reset sequencer: FSM state encoding,
// reset-cause codes and the per-state output decode.
package por_seq_pkg;

  typedef enum logic [2:0] {
    ASSERT  = 3'd0,
    FILTER  = 3'd1,
    HOLD    = 3'd2,
    CORE_UP = 3'd3,
    RUN     = 3'd4
  } state_e;

  // last_cause bit 1 = external pin low, bit 0 = POR low.
  localparam logic [1:0] CAUSE_SW   = 2'b00;
  localparam logic [1:0] CAUSE_POR  = 2'b01;
  localparam logic [1:0] CAUSE_EXT  = 2'b10;
  localparam logic [1:0] CAUSE_BOTH = 2'b11;

  typedef struct packed {
    logic core;
    logic periph;
    logic done;
  } rst_out_t;

  function automatic rst_out_t decode_outputs(input state_e st);
    rst_out_t o;
    o = '{core: 1'b1, periph: 1'b1, done: 1'b0};
    unique case (st)
      CORE_UP: o = '{core: 1'b0, periph: 1'b1, done: 1'b0};
      RUN:     o = '{core: 1'b0, periph: 1'b0, done: 1'b1};
      default: o = '{core: 1'b1, periph: 1'b1, done: 1'b0};
    endcase
    return o;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/reset_sync_chain.sv
// Multi-flop synchronizer for an asynchronous reset-request input; cleared to 0 by the
// synchronous block reset so a held reset always reads as "asserted" downstream.
module reset_sync_chain #(
  parameter int unsigned STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] flops_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      flops_q <= '0;
    end else begin
      flops_q <= {flops_q[STAGES-2:0], d};
    end
  end

  assign q = flops_q[STAGES-1];

endmodule

// File: rtl/por_reset_sequencer.sv
// Power-on reset sequencer: synchronizes POR and pin resets, filters them, then releases
// the core reset followed by the peripheral reset; supports software peripheral reset.
module por_reset_sequencer
  import por_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 16,
  parameter int unsigned HOLD_CYCLES   = 64,
  parameter int unsigned STAGE_GAP     = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       porb_in,
  input  logic       ext_resetb_in,
  input  logic       sw_periph_reset,
  output logic       rst_core,
  output logic       rst_periph,
  output logic       reset_done,
  output logic [1:0] last_cause
);

  localparam int unsigned CNT_W = $clog2(max3(FILTER_CYCLES, HOLD_CYCLES, STAGE_GAP) + 1);

  localparam logic [CNT_W-1:0] FILTER_LAST = CNT_W'(FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic porb_s;
  logic extb_s;
  logic clean;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cause_d;
  rst_out_t         outs_d;

  reset_sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync_porb (
    .clock (clock),
    .reset (reset),
    .d     (porb_in),
    .q     (porb_s)
  );

  reset_sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync_extb (
    .clock (clock),
    .reset (reset),
    .d     (ext_resetb_in),
    .q     (extb_s)
  );

  assign clean = porb_s & extb_s;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = last_cause;
    // A dirty sample anywhere past ASSERT restarts the whole sequence with no credit kept.
    if ((state_q != ASSERT) && !clean) begin
      state_d = ASSERT;
      cnt_d   = '0;
      cause_d = {~extb_s, ~porb_s};
    end else begin
      unique case (state_q)
        ASSERT: begin
          if (clean) begin
            state_d = FILTER;
            cnt_d   = '0;
          end
        end
        FILTER: begin
          if (cnt_q == FILTER_LAST) begin
            state_d = HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = CORE_UP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        CORE_UP: begin
          if (cnt_q == GAP_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        RUN: begin
          if (sw_periph_reset) begin
            state_d = CORE_UP;
            cnt_d   = '0;
            cause_d = CAUSE_SW;
          end
        end
        default: begin
          state_d = ASSERT;
          cnt_d   = '0;
        end
      endcase
    end
    outs_d = decode_outputs(state_d);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ASSERT;
      cnt_q      <= '0;
      rst_core   <= 1'b1;
      rst_periph <= 1'b1;
      reset_done <= 1'b0;
      last_cause <= CAUSE_POR;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rst_core   <= outs_d.core;
      rst_periph <= outs_d.periph;
      reset_done <= outs_d.done;
      last_cause <= cause_d;
    end
  end

`ifndef SYNTHESIS
  // Peripherals must never leave reset while the core is still held.
  core_implies_periph : assert property (@(posedge clock) rst_core |-> rst_periph);
`endif

endmodule

// File: tb/tb_por_reset_sequencer.sv
// Self-checking bench for por_reset_sequencer: vector table, directed corner sequences and
// randomized pad/software activity compared against a timeline-based reference model.
module tb_por_reset_sequencer;

  localparam int unsigned SYNC  = 2;
  localparam int unsigned FILT  = 16;
  localparam int unsigned HOLDC = 64;
  localparam int unsigned GAP   = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       porb_in = 1'b0;
  logic       ext_resetb_in = 1'b1;
  logic       sw_periph_reset = 1'b0;
  logic       rst_core;
  logic       rst_periph;
  logic       reset_done;
  logic [1:0] last_cause;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clock = ~clock;

  por_reset_sequencer #(
    .SYNC_STAGES   (SYNC),
    .FILTER_CYCLES (FILT),
    .HOLD_CYCLES   (HOLDC),
    .STAGE_GAP     (GAP)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .porb_in         (porb_in),
    .ext_resetb_in   (ext_resetb_in),
    .sw_periph_reset (sw_periph_reset),
    .rst_core        (rst_core),
    .rst_periph      (rst_periph),
    .reset_done      (reset_done),
    .last_cause      (last_cause)
  );

  // Reference model: pad samples delayed by SYNC edges, then a release timeline t counted
  // from the edge the sequencer first sees both pads clean, plus a separate sw timeline.
  bit [SYNC-1:0] m_pq = '0;
  bit [SYNC-1:0] m_eq = '0;
  bit            m_idle = 1'b1;
  bit            m_swm = 1'b0;
  int            m_t = 0;
  int            m_ts = 0;
  bit [1:0]      m_cause = 2'b01;
  bit            m_core = 1'b1;
  bit            m_periph = 1'b1;
  bit            m_done = 1'b0;

  task automatic model_step();
    bit ps, es;
    ps = m_pq[SYNC-1];
    es = m_eq[SYNC-1];
    if (reset) begin
      m_pq = '0; m_eq = '0; m_idle = 1'b1; m_swm = 1'b0; m_t = 0; m_ts = 0;
      m_cause = 2'b01;
    end else begin
      if (m_idle) begin
        if (ps && es) begin
          m_idle = 1'b0; m_swm = 1'b0; m_t = 0;
        end
      end else if (!(ps && es)) begin
        m_idle  = 1'b1;
        m_cause = {~es, ~ps};
      end else if (m_done && sw_periph_reset) begin
        m_swm = 1'b1; m_ts = 0; m_cause = 2'b00;
      end else begin
        m_t++;
        m_ts++;
      end
      m_pq = {m_pq[SYNC-2:0], porb_in};
      m_eq = {m_eq[SYNC-2:0], ext_resetb_in};
    end
    m_core   = m_idle || (m_t < int'(FILT + HOLDC));
    m_periph = m_core || (m_swm ? (m_ts < int'(GAP)) : (m_t < int'(FILT + HOLDC + GAP)));
    m_done   = !m_periph;
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic check_outs(input string name, input bit core, input bit periph,
                            input bit done, input bit [1:0] cause);
    checks++;
    if ({rst_core, rst_periph, reset_done, last_cause} !== {core, periph, done, cause}) begin
      errors++;
      $display("FAIL %s edge %0d: got core=%b periph=%b done=%b cause=%b, expected core=%b periph=%b done=%b cause=%b",
               name, cyc, rst_core, rst_periph, reset_done, last_cause, core, periph, done, cause);
    end
  endtask

  typedef struct {
    bit       rst;
    bit       porb;
    bit       ext;
    int       n;
    bit       core;
    bit       periph;
    bit       done;
    bit [1:0] cause;
    string    name;
  } vec_t;

  function automatic vec_t mk(input bit rst, input bit porb, input bit ext, input int n,
                              input bit core, input bit periph, input bit done,
                              input bit [1:0] cause, input string name);
    vec_t v;
    v.rst = rst; v.porb = porb; v.ext = ext; v.n = n;
    v.core = core; v.periph = periph; v.done = done; v.cause = cause; v.name = name;
    return v;
  endfunction

  vec_t vecs[12];

  initial begin
    int p, g, s, x, y, r;
    int p_low, e_low;

    // Each row: drive inputs, advance n edges, then compare.
    vecs[0]  = mk(1, 0, 1,  3, 1, 1, 0, 2'b01, "reset_state");
    vecs[1]  = mk(0, 0, 1,  5, 1, 1, 0, 2'b01, "por_low");
    vecs[2]  = mk(0, 1, 1, 82, 1, 1, 0, 2'b01, "por_core_held_p81");
    vecs[3]  = mk(0, 1, 1,  1, 0, 1, 0, 2'b01, "por_core_rel_p82");
    vecs[4]  = mk(0, 1, 1,  7, 0, 1, 0, 2'b01, "por_periph_held_p89");
    vecs[5]  = mk(0, 1, 1,  1, 0, 0, 1, 2'b01, "por_periph_rel_p90");
    vecs[6]  = mk(0, 1, 0,  2, 0, 0, 1, 2'b01, "ext_low_in_sync");
    vecs[7]  = mk(0, 1, 0,  1, 1, 1, 0, 2'b10, "ext_assert_p2");
    vecs[8]  = mk(0, 1, 1, 82, 1, 1, 0, 2'b10, "ext_core_held");
    vecs[9]  = mk(0, 1, 1,  1, 0, 1, 0, 2'b10, "ext_core_rel");
    vecs[10] = mk(0, 1, 1,  7, 0, 1, 0, 2'b10, "ext_periph_held");
    vecs[11] = mk(0, 1, 1,  1, 0, 0, 1, 2'b10, "ext_periph_rel");

    for (int i = 0; i < 12; i++) begin
      reset         = vecs[i].rst;
      porb_in       = vecs[i].porb;
      ext_resetb_in = vecs[i].ext;
      repeat (vecs[i].n) tick();
      check_outs(vecs[i].name, vecs[i].core, vecs[i].periph, vecs[i].done, vecs[i].cause);
    end

    // Software peripheral reset in RUN; a second request during CORE_UP is ignored.
    sw_periph_reset = 1'b1;
    s = cyc + 1;
    tick();
    sw_periph_reset = 1'b0;
    check_outs("sw_assert", 0, 1, 0, 2'b00);
    wait_to(s + 2);
    sw_periph_reset = 1'b1;
    tick();
    sw_periph_reset = 1'b0;
    wait_to(s + 7);
    check_outs("sw_periph_held_s7", 0, 1, 0, 2'b00);
    tick();
    check_outs("sw_periph_rel_s8", 0, 0, 1, 2'b00);

    // One-cycle POR glitch while in HOLD restarts the full sequence.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    p = cyc + 1;
    wait_to(p + 39);
    porb_in = 1'b0;
    tick();
    g = cyc;
    porb_in = 1'b1;
    check_outs("glitch_outputs_held", 1, 1, 0, 2'b01);
    wait_to(p + 82);
    check_outs("glitch_no_early_release", 1, 1, 0, 2'b01);
    wait_to(g + 82);
    check_outs("glitch_core_held", 1, 1, 0, 2'b01);
    tick();
    check_outs("glitch_core_rel", 0, 1, 0, 2'b01);
    wait_to(g + 91);
    check_outs("glitch_run", 0, 0, 1, 2'b01);

    // Software request on the same edge as a pin reset: pin reset wins.
    ext_resetb_in = 1'b0;
    x = cyc + 1;
    tick();
    tick();
    sw_periph_reset = 1'b1;
    tick();
    sw_periph_reset = 1'b0;
    check_outs("sw_vs_ext_edge", 1, 1, 0, 2'b10);
    ext_resetb_in = 1'b1;
    y = x + 3;

    // Software request during HOLD is ignored.
    wait_to(y + 29);
    sw_periph_reset = 1'b1;
    tick();
    sw_periph_reset = 1'b0;
    check_outs("sw_in_hold_ignored", 1, 1, 0, 2'b10);
    wait_to(y + 81);
    check_outs("hold_core_held", 1, 1, 0, 2'b10);
    tick();
    check_outs("hold_core_rel", 0, 1, 0, 2'b10);

    // Block reset during CORE_UP.
    wait_to(y + 84);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_outs("reset_in_core_up", 1, 1, 0, 2'b01);
    r = cyc + 1;
    wait_to(r + 81);
    check_outs("after_reset_core_held", 1, 1, 0, 2'b01);
    tick();
    check_outs("after_reset_core_rel", 0, 1, 0, 2'b01);
    wait_to(r + 90);
    check_outs("after_reset_run", 0, 0, 1, 2'b01);

    // Randomized pad glitches, sw pulses and occasional block resets against the model.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    p_low = 0;
    e_low = 0;
    for (int i = 0; i < 6000; i++) begin
      if (p_low == 0 && $urandom_range(399) == 0) p_low = $urandom_range(6, 1);
      if (e_low == 0 && $urandom_range(399) == 0) e_low = $urandom_range(6, 1);
      porb_in       = (p_low == 0);
      ext_resetb_in = (e_low == 0);
      if (p_low > 0) p_low--;
      if (e_low > 0) e_low--;
      sw_periph_reset = ($urandom_range(15) == 0);
      reset           = ($urandom_range(1499) == 0);
      tick();
      check_outs("random_vs_model", m_core, m_periph, m_done, m_cause);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
